// File: rtl/rom_scan_ctrl_pkg.sv
// Shared constants for the ROM scan controller: default widths, FSM state codes
// and sizing helpers.
package rom_scan_ctrl_pkg;

  localparam int ADDR_W_DEF     = 4;
  localparam int DATA_W_DEF     = 16;
  localparam int RD_LAT_DEF     = 1;
  localparam int FIFO_DEPTH_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Width needed to hold an occupancy value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rom_scan_fifo.sv
// First-word-fall-through synchronous FIFO: dout always shows the oldest entry,
// count/empty/full reflect registered occupancy.
module rom_scan_fifo
  import rom_scan_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = DATA_W_DEF,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == {CNT_W{1'b0}});
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; a push into a full FIFO is
  // only accepted when the head leaves in the same cycle.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
  end

  // Storage and pointer registers; reset clears contents so dout reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rom_scan_ctrl.sv
// Sequencer for a synchronous ROM: steps an inclusive address range (optionally
// looping), absorbs read latency and streams words out on valid/ready.
module rom_scan_ctrl
  import rom_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int SUM_W = CNT_W + $clog2(RD_LAT + 2) + 1;

  logic [1:0]        state_q, state_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] span_q, span_d;
  logic              loop_q, loop_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              pop_s;
  logic              push_s;
  logic [SUM_W-1:0]  infl_s;
  logic [SUM_W-1:0]  occ_s;
  logic              credit_s;
  logic              drained_s;

  assign out_valid = ~fifo_empty_s;
  assign pop_s     = out_valid & out_ready;
  assign push_s    = vld_q[RD_LAT-1];

  rom_scan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (rom_data),
    .pop   (pop_s),
    .dout  (out_data),
    .count (fifo_count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Credit: every read already on its way (including the one issuing now) owns
  // a buffer slot, so a new issue can never overflow the FIFO.
  always_comb begin
    infl_s = SUM_W'(rom_en_q);
    for (int i = 0; i < RD_LAT; i++) begin
      infl_s = infl_s + SUM_W'(vld_q[i]);
    end
    occ_s     = SUM_W'(fifo_count_s) + infl_s - SUM_W'(pop_s);
    credit_s  = (occ_s < SUM_W'(FIFO_DEPTH)) & ~(fifo_full_s & ~pop_s);
    drained_s = fifo_empty_s & (infl_s == {SUM_W{1'b0}});
  end

  // FSM, address stepping and remaining-word bookkeeping. rem_q counts issues
  // still owed after the one currently on rom_addr; at zero a loop scan rewinds.
  always_comb begin
    state_d     = state_q;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    next_addr_d = next_addr_q;
    rem_d       = rem_q;
    first_d     = first_q;
    span_d      = span_q;
    loop_d      = loop_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          rom_en_d    = 1'b1;
          rom_addr_d  = first_addr;
          next_addr_d = first_addr + ADDR_W'(1);
          rem_d       = last_addr - first_addr;
          span_d      = last_addr - first_addr;
          first_d     = first_addr;
          loop_d      = loop;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if ((rem_q == {ADDR_W{1'b0}}) && !loop_q) begin
          state_d = ST_DRAIN;
        end else if (credit_s) begin
          rom_en_d = 1'b1;
          if (rem_q == {ADDR_W{1'b0}}) begin
            rom_addr_d  = first_q;
            next_addr_d = first_q + ADDR_W'(1);
            rem_d       = span_q;
          end else begin
            rom_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(1);
            rem_d       = rem_q - ADDR_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DRAIN) & drained_s;
    vld_d  = RD_LAT'({vld_q, rom_en_q});
  end

  // Control registers; reset discards in-flight reads along with the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= {ADDR_W{1'b0}};
      next_addr_q <= {ADDR_W{1'b0}};
      rem_q       <= {ADDR_W{1'b0}};
      first_q     <= {ADDR_W{1'b0}};
      span_q      <= {ADDR_W{1'b0}};
      loop_q      <= 1'b0;
      vld_q       <= {RD_LAT{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      next_addr_q <= next_addr_d;
      rem_q       <= rem_d;
      first_q     <= first_d;
      span_q      <= span_d;
      loop_q      <= loop_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
